// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: bundle field offsets, ALU control
// encodings, R-type funct codes and the internal ALU operation set.
package ex_pkg;

   localparam int SIZE = 32;
   localparam int RW   = $clog2(SIZE);
   localparam int W    = RW + 4*SIZE + 10;

   // ID/EX bundle offsets (LSB of each field)
   localparam int ID_CTL_LSB  = 0;
   localparam int ID_IMM_LSB  = 10;
   localparam int ID_RT_LSB   = ID_IMM_LSB + SIZE;
   localparam int ID_RS_LSB   = ID_RT_LSB + SIZE;
   localparam int ID_PC4_LSB  = ID_RS_LSB + SIZE;
   localparam int ID_WREG_LSB = ID_PC4_LSB + SIZE;

   // EX/MEM bundle offsets (LSB of each field)
   localparam int EM_CTL_LSB  = 0;
   localparam int EM_PC4_LSB  = 10;
   localparam int EM_RT_LSB   = EM_PC4_LSB + SIZE;
   localparam int EM_ALU_LSB  = EM_RT_LSB + SIZE;
   localparam int EM_BTGT_LSB = EM_ALU_LSB + SIZE;
   localparam int EM_WREG_LSB = EM_BTGT_LSB + SIZE;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_OR    = 2'b11;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SRL, ALU_SRA
   } alu_fn_e;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; overflow is reported only for ADD and SUB.
module alu
   import ex_pkg::*;
(
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic [RW-1:0]   shamt,
   input  alu_fn_e         op,
   output logic [SIZE-1:0] result,
   output logic            zero,
   output logic            overflow
);

   logic [SIZE-1:0] sum;
   logic [SIZE-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      result   = sum;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            result   = sum;
            overflow = (a[SIZE-1] == b[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);
         end
         ALU_SUB: begin
            result   = diff;
            overflow = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]);
         end
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(SIZE-1){1'b0}}, (a < b)};
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
         default:  result = sum;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU control decode, branch target adder and
// the EX/MEM pipeline register. Fixed one-cycle latency; no valid/ready handshake.
module ex_stage
   import ex_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] ID_EX,
   output logic [W-1:0] EX_MEM
);

   logic [RW-1:0]   wreg;
   logic [SIZE-1:0] pc4, rs_val, rt_val, imm;
   logic [9:0]      ctl;
   logic [1:0]      alu_op;
   logic            alu_src;

   assign wreg    = ID_EX[ID_WREG_LSB +: RW];
   assign pc4     = ID_EX[ID_PC4_LSB  +: SIZE];
   assign rs_val  = ID_EX[ID_RS_LSB   +: SIZE];
   assign rt_val  = ID_EX[ID_RT_LSB   +: SIZE];
   assign imm     = ID_EX[ID_IMM_LSB  +: SIZE];
   assign ctl     = ID_EX[ID_CTL_LSB  +: 10];
   assign alu_op  = ctl[4:3];
   assign alu_src = ctl[2];

   logic [SIZE-1:0] op_b;
   logic [SIZE-1:0] btgt;
   alu_fn_e         alu_fn;
   logic [SIZE-1:0] alu_result;
   logic            alu_zero, alu_ovf;

   assign op_b = alu_src ? imm : rt_val;
   assign btgt = pc4 + (imm << 2);

   always_comb begin
      alu_fn = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_fn = ALU_ADD;
         ALU_OP_SUB: alu_fn = ALU_SUB;
         ALU_OP_OR:  alu_fn = ALU_OR;
         default: begin
            // Unknown funct codes fall back to ADD.
            case (imm[5:0])
               FN_SLL, FN_ADD, FN_ADDU: alu_fn = ALU_ADD;
               FN_SUB, FN_SUBU:         alu_fn = ALU_SUB;
               FN_AND:                  alu_fn = ALU_AND;
               FN_OR:                   alu_fn = ALU_OR;
               FN_XOR:                  alu_fn = ALU_XOR;
               FN_NOR:                  alu_fn = ALU_NOR;
               FN_SLT:                  alu_fn = ALU_SLT;
               FN_SLTU:                 alu_fn = ALU_SLTU;
               FN_SRL:                  alu_fn = ALU_SRL;
               FN_SRA:                  alu_fn = ALU_SRA;
               default:                 alu_fn = ALU_ADD;
            endcase
         end
      endcase
   end

   alu u_alu (
      .a        (rs_val),
      .b        (op_b),
      .shamt    (imm[10:6]),
      .op       (alu_fn),
      .result   (alu_result),
      .zero     (alu_zero),
      .overflow (alu_ovf)
   );

   logic [W-1:0] ex_mem_d, ex_mem_q;

   always_comb begin
      ex_mem_d = {wreg, btgt, alu_result, rt_val, pc4,
                  ctl[9:5], alu_zero, alu_ovf, 1'b0, ctl[1], ctl[0]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ex_mem_q <= '0;
      else        ex_mem_q <= ex_mem_d;
   end

   assign EX_MEM = ex_mem_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: reference model feeds an expected queue,
// directed scenarios plus randomised bundles and mid-stream resets.
module tb_ex_stage;

   localparam int WB = 143;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [WB-1:0] id_ex;
   logic [WB-1:0] ex_mem;

   logic [WB-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   ex_stage dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ID_EX  (id_ex),
      .EX_MEM (ex_mem)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [WB-1:0] mk(input logic [4:0] wreg, input logic [31:0] pc4,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] imm, input logic [9:0] ctl);
      return {wreg, pc4, rs, rt, imm, ctl};
   endfunction

   function automatic logic [WB-1:0] model(input logic [WB-1:0] x);
      logic [4:0]  wreg;
      logic [31:0] pc4, a, rt, imm, b, r, btgt;
      logic [9:0]  ctl;
      logic [32:0] s;
      logic        ovf;
      {wreg, pc4, a, rt, imm, ctl} = x;
      b    = ctl[2] ? imm : rt;
      btgt = pc4 + {imm[29:0], 2'b00};
      ovf  = 1'b0;
      r    = a + b;
      s    = {a[31], a} + {b[31], b};
      case (ctl[4:3])
         2'b00: ovf = s[32] ^ s[31];
         2'b01: begin
            r = a - b;
            s = {a[31], a} - {b[31], b};
            ovf = s[32] ^ s[31];
         end
         2'b11: r = a | b;
         default: begin
            case (imm[5:0])
               6'h22, 6'h23: begin
                  r = a - b;
                  s = {a[31], a} - {b[31], b};
                  ovf = s[32] ^ s[31];
               end
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h26: r = a ^ b;
               6'h27: r = ~(a | b);
               6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: r = (a < b) ? 32'd1 : 32'd0;
               6'h02: r = b >> imm[10:6];
               6'h03: r = $signed(b) >>> imm[10:6];
               default: ovf = s[32] ^ s[31];
            endcase
         end
      endcase
      return {wreg, btgt, r, rt, pc4, ctl[9:5], (r == 32'd0), ovf, 1'b0, ctl[1], ctl[0]};
   endfunction

   // Drive one bundle for one edge; the expected EX_MEM is queued on drive and
   // compared one edge later.
   task automatic step(input logic [WB-1:0] in, input logic rst_assert);
      @(negedge clk);
      id_ex = in;
      rst_n = !rst_assert;
      exp_q.push_back(rst_assert ? '0 : model(in));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check("queue_empty", 1, 0);
      else check("ex_mem", ex_mem, exp_q.pop_front());
   endtask

   logic [WB-1:0] s1, v;
   logic [5:0]    fn_tab[13];

   initial begin
      rst_n = 1'b0;
      id_ex = '0;
      fn_tab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

      step('0, 1'b1);
      check("reset_zero", ex_mem, '0);

      // 1: R-type ADD, then hold
      s1 = mk(5'h12, 32'h0, 32'h10082010, 32'h00080102, 32'h0, 10'b1000010001);
      step(s1, 1'b0);
      check("s1_alu", ex_mem[105:74], 32'h10102112);
      check("s1_wreg", ex_mem[142:138], 5'h12);
      check("s1_btgt", ex_mem[137:106], 32'h0);
      check("s1_store", ex_mem[73:42], 32'h00080102);
      check("s1_ctl", ex_mem[9:0], 10'b1000000001);
      v = ex_mem;
      for (int i = 0; i < 3; i++) begin
         step(s1, 1'b0);
         check("s1_hold", ex_mem, v);
      end

      // 2: reset overrides input, release reloads
      step(s1, 1'b1);
      check("s2_reset", ex_mem, '0);
      step(s1, 1'b0);
      check("s2_reload", ex_mem, v);

      // 3: immediate SUB to zero, branch
      step(mk(5'h3, 32'h100, 32'd5, 32'hDEAD, 32'd5, 10'b0000101101), 1'b0);
      check("s3_alu", ex_mem[105:74], 32'h0);
      check("s3_zero", ex_mem[4], 1'b1);
      check("s3_btgt", ex_mem[137:106], 32'h114);
      check("s3_branch", ex_mem[5], 1'b1);

      // 4: signed overflow on ADD
      step(mk(5'h4, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 10'b1000000001), 1'b0);
      check("s4_alu", ex_mem[105:74], 32'h80000000);
      check("s4_ovf", ex_mem[3], 1'b1);
      check("s4_zero", ex_mem[4], 1'b0);

      // 5: funct decode
      step(mk(5'h5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h2A, 10'b1000010001), 1'b0);
      check("s5_slt", ex_mem[105:74], 32'h1);
      step(mk(5'h5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h2B, 10'b1000010001), 1'b0);
      check("s5_sltu", ex_mem[105:74], 32'h0);
      step(mk(5'h5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h24, 10'b1000010001), 1'b0);
      check("s5_and", ex_mem[105:74], 32'h1);
      step(mk(5'h5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h27, 10'b1000010001), 1'b0);
      check("s5_nor", ex_mem[105:74], 32'h0);
      check("s5_nor_ovf", ex_mem[3], 1'b0);
      step(mk(5'h5, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h103, 10'b1000010001), 1'b0);
      check("s5_sra", ex_mem[105:74], 32'hF8000000);

      // 6: negative branch offset
      step(mk(5'h6, 32'h200, 32'h0, 32'h0, 32'hFFFFFFFF, 10'b0000100101), 1'b0);
      check("s6_btgt", ex_mem[137:106], 32'h1FC);

      // valid = 0 bundle still computed, controls forwarded
      step(mk(5'h7, 32'h40, 32'h3, 32'h4, 32'h0, 10'b1111100010), 1'b0);
      check("inv_valid", ex_mem[0], 1'b0);
      check("inv_ctl", ex_mem[9:5], 5'b11111);
      check("inv_jump", ex_mem[1], 1'b1);

      // randomised bundles with occasional resets
      for (int i = 0; i < 60; i++) begin
         logic [31:0] imm;
         imm = $urandom;
         if ($urandom_range(0, 1) == 1) imm[5:0] = fn_tab[$urandom_range(0, 12)];
         v = mk(5'($urandom), $urandom, $urandom, $urandom, imm, 10'($urandom));
         if ($urandom_range(0, 3) == 0) v[73:42] = v[105:74];
         step(v, ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
